// File: rtl/rotary_pkg.sv
// Shared types and constants for the rotary parameter controller.
package rotary_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SEND} state_e;

    localparam int DEF_W      = 16;
    localparam int DEF_NPARAM = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rotary_accel.sv
// Step acceleration: tracks the gap since the last accepted step and the
// acceleration level, and presents the step size for the current cycle.
module rotary_accel #(
    parameter int W         = 16,
    parameter int ACCEL_WIN = 1000000,
    parameter int ACCEL_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step_acc,
    input  logic         clr,
    output logic [W:0]   step_size
);

    localparam int GW = $clog2(ACCEL_WIN + 1);
    localparam int LW = $clog2(ACCEL_MAX + 2);

    logic [GW-1:0] gap_q, gap_d;
    logic [LW-1:0] level_q, level_d, new_level;

    always_comb begin
        if (gap_q < GW'(ACCEL_WIN))
            new_level = (level_q >= LW'(ACCEL_MAX)) ? LW'(ACCEL_MAX) : level_q + LW'(1);
        else
            new_level = '0;
        step_size = (W+1)'(1) << new_level;

        gap_d   = gap_q;
        level_d = level_q;
        // A selection change wins over a same-cycle step: the step still uses
        // new_level, but the next parameter starts slow.
        if (clr) begin
            level_d = '0;
            gap_d   = GW'(ACCEL_WIN);
        end else if (step_acc) begin
            level_d = new_level;
            gap_d   = '0;
        end else if (gap_q != GW'(ACCEL_WIN)) begin
            gap_d = gap_q + GW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q   <= GW'(ACCEL_WIN);
            level_q <= '0;
        end else begin
            gap_q   <= gap_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/rotary_param_ctrl.sv
// Rotary-driven saturating parameter bank with acceleration and a settled
// update channel towards the display/strobe datapath.
module rotary_param_ctrl
    import rotary_pkg::*;
#(
    parameter int             NPARAM     = DEF_NPARAM,
    parameter int             W          = DEF_W,
    parameter logic [W-1:0]   PMAX       = '1,
    parameter logic [W-1:0]   PARAM_INIT = W'(16'h0100),
    parameter int             ACCEL_WIN  = 1000000,
    parameter int             ACCEL_MAX  = 4,
    parameter int             SETTLE     = 2000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        step_cw,
    input  logic                        step_ccw,
    input  logic                        sel_next,
    output logic [NPARAM*W-1:0]         param_flat,
    output logic [$clog2(NPARAM)-1:0]   sel_idx,
    output logic                        upd_valid,
    output logic [$clog2(NPARAM)-1:0]   upd_idx,
    output logic [W-1:0]                upd_data,
    input  logic                        upd_ready
);

    localparam int IW = idx_w(NPARAM);
    localparam int CW = $clog2(SETTLE + 1);

    logic [NPARAM-1:0][W-1:0] params_q, params_d;
    logic [IW-1:0]            sel_idx_q, sel_idx_d;
    logic [NPARAM-1:0]        dirty_q, dirty_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    state_e                   state_q;
    logic                     upd_valid_q, chg_q;
    logic [IW-1:0]            upd_idx_q, low_idx;
    logic [W-1:0]             upd_data_q, p_cur, p_new;
    logic [W:0]               sum, step_size;
    logic                     step_acc, changed, hit_upd, hs;

    assign step_acc = step_cw ^ step_ccw;

    rotary_accel #(
        .W         (W),
        .ACCEL_WIN (ACCEL_WIN),
        .ACCEL_MAX (ACCEL_MAX)
    ) u_accel (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_acc  (step_acc),
        .clr       (sel_next),
        .step_size (step_size)
    );

    always_comb begin
        p_cur = params_q[sel_idx_q];
        sum   = {1'b0, p_cur} + step_size;
        if (step_cw)
            p_new = (sum > {1'b0, PMAX}) ? PMAX : sum[W-1:0];
        else
            p_new = ({1'b0, p_cur} < step_size) ? '0 : p_cur - step_size[W-1:0];
        changed = step_acc && (p_new != p_cur);

        params_d = params_q;
        if (changed)
            params_d[sel_idx_q] = p_new;

        sel_idx_d = sel_idx_q;
        if (sel_next)
            sel_idx_d = (sel_idx_q == IW'(NPARAM - 1)) ? '0 : sel_idx_q + IW'(1);

        // A change to the offered parameter during SEND keeps it dirty so the
        // newer value is offered again after this handshake.
        hs      = upd_valid_q && upd_ready;
        hit_upd = changed && (sel_idx_q == upd_idx_q);
        dirty_d = dirty_q;
        if (hs && !(chg_q || hit_upd))
            dirty_d[upd_idx_q] = 1'b0;
        if (changed)
            dirty_d[sel_idx_q] = 1'b1;

        if (changed)
            cnt_d = CW'(SETTLE);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
        else
            cnt_d = cnt_q;

        low_idx = '0;
        for (int i = NPARAM - 1; i >= 0; i--)
            if (dirty_q[i]) low_idx = IW'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            params_q  <= {NPARAM{PARAM_INIT}};
            sel_idx_q <= '0;
            dirty_q   <= '0;
            cnt_q     <= '0;
        end else begin
            params_q  <= params_d;
            sel_idx_q <= sel_idx_d;
            dirty_q   <= dirty_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_data_q  <= '0;
            chg_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dirty_q != '0) state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (dirty_q == '0) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q     <= ST_SEND;
                        upd_valid_q <= 1'b1;
                        upd_idx_q   <= low_idx;
                        upd_data_q  <= params_d[low_idx];
                        chg_q       <= 1'b0;
                    end
                end
                ST_SEND: begin
                    // Passing through SETTLE guarantees a dead cycle between offers.
                    if (hs) begin
                        upd_valid_q <= 1'b0;
                        state_q     <= (dirty_d == '0) ? ST_IDLE : ST_SETTLE;
                    end else if (hit_upd) begin
                        chg_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign param_flat = params_q;
    assign sel_idx    = sel_idx_q;
    assign upd_valid  = upd_valid_q;
    assign upd_idx    = upd_idx_q;
    assign upd_data   = upd_data_q;

endmodule
